fir_decimator: RTL and testbench

//   Downstream consumer of the 5-tap FIR output. Sums every DECIM consecutive
//   FIR samples into one wider word (integrate-and-dump decimation) and queues
//   the results in a small FIFO. The FIFO drains over a valid/ready interface,
//   and a saturating counter records blocks lost to backpressure.

---
 rtl/fir_decimator.sv | 114 +++++++++++
 tb/tb_fir_decimator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// Module   : fir_decimator
// Summary  : Integrate-and-dump decimator for FIR samples, with a result FIFO
//            and a saturating counter of blocks lost to backpressure.
// Revision : 1.0
// ============================================================================
module fir_decimator #(
  parameter int IN_WIDTH   = 16,
  parameter int DECIM      = 4,
  parameter int OUT_WIDTH  = IN_WIDTH + $clog2(DECIM),
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_WIDTH-1:0]      in_data,
  input  logic                     in_en,
  input  logic                     flush,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_partial,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DECIM)-1:0] phase,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int c_ph_w  = $clog2(DECIM);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_ph_w-1:0]  c_last = c_ph_w'(DECIM - 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);

  logic [OUT_WIDTH-1:0] r_acc;
  logic [c_ph_w-1:0]    r_phase;
  logic [OUT_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [DROP_W-1:0]    r_drop;

  logic [OUT_WIDTH-1:0] w_sum;
  logic                 w_close;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr;
  logic                 w_drop;

  assign w_sum   = r_acc + (in_en ? OUT_WIDTH'(in_data) : '0);
  assign w_close = in_en && (r_phase == c_last);
  // A flush on an empty block with no sample has nothing to report.
  assign w_push  = w_close || (flush && (in_en || (r_phase != '0)));
  assign w_pop   = (r_count != '0) && out_ready;
  assign w_full  = (r_count == c_full);
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (w_push) begin
      r_acc   <= '0;
      r_phase <= '0;
    end else if (in_en) begin
      r_acc   <= w_sum;
      r_phase <= r_phase + c_ph_w'(1);
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {!w_close, w_sum};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
      r_drop <= r_drop + DROP_W'(1);
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_data    = out_valid ? r_mem[r_rd_ptr][OUT_WIDTH-1:0] : '0;
  assign out_partial = out_valid ? r_mem[r_rd_ptr][OUT_WIDTH] : 1'b0;
  assign phase       = r_phase;
  assign drop_count  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fir_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_decimator
// Summary  : Directed vector table plus hand-written corner-case sequences.
// Revision : 1.0
// ============================================================================
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_en = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] out_data;
  logic        out_partial;
  logic        out_valid;
  logic [1:0]  phase;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] d;
    logic        en;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [17:0] ed;
    logic        ep;
    logic [1:0]  eph;
  } vec_t;

  vec_t vecs [28];

  fir_decimator dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_en       (in_en),
    .flush       (flush),
    .out_data    (out_data),
    .out_partial (out_partial),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .phase       (phase),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_block(input logic [15:0] val);
    for (int k = 0; k < 4; k++) begin
      in_data = val;
      in_en   = 1'b1;
      step();
    end
    in_en = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[1]  = '{16'd2,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd2};
    vecs[2]  = '{16'd3,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd3};
    vecs[3]  = '{16'd4,    1'b1, 1'b0, 1'b1, 1'b1, 18'd10,      1'b0, 2'd0};
    vecs[4]  = '{16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};
    vecs[5]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[6]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd2};
    vecs[7]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd3};
    vecs[8]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 18'h3FFFC,   1'b0, 2'd0};
    vecs[9]  = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[10] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd2};
    vecs[11] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd3};
    vecs[12] = '{16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 18'h3FFFC,   1'b0, 2'd0};
    vecs[13] = '{16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};
    vecs[14] = '{16'd7,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[15] = '{16'd7,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd2};
    vecs[16] = '{16'd7,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd3};
    vecs[17] = '{16'd0,    1'b0, 1'b1, 1'b1, 1'b1, 18'd21,      1'b1, 2'd0};
    vecs[18] = '{16'd0,    1'b0, 1'b1, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};
    vecs[19] = '{16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};
    vecs[20] = '{16'd3,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[21] = '{16'd4,    1'b1, 1'b1, 1'b1, 1'b1, 18'd7,       1'b1, 2'd0};
    vecs[22] = '{16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};
    vecs[23] = '{16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd1};
    vecs[24] = '{16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd2};
    vecs[25] = '{16'd1,    1'b1, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd3};
    vecs[26] = '{16'd1,    1'b1, 1'b1, 1'b1, 1'b1, 18'd4,       1'b0, 2'd0};
    vecs[27] = '{16'd0,    1'b0, 1'b0, 1'b1, 1'b0, 18'd0,       1'b0, 2'd0};

    // Reset state
    #1;
    check("reset_valid",   32'(out_valid),   32'd0);
    check("reset_data",    32'(out_data),    32'd0);
    check("reset_partial", 32'(out_partial), 32'd0);
    check("reset_phase",   32'(phase),       32'd0);
    check("reset_drop",    32'(drop_count),  32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic, max-value, flush and flush-on-close vectors
    for (int i = 0; i < 28; i++) begin
      in_data   = vecs[i].d;
      in_en     = vecs[i].en;
      flush     = vecs[i].fl;
      out_ready = vecs[i].rdy;
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_phase", i), 32'(phase),     32'(vecs[i].eph));
      check($sformatf("v%0d_drop", i),  32'(drop_count), 32'd0);
      if (vecs[i].ev) begin
        check($sformatf("v%0d_data", i),    32'(out_data),    32'(vecs[i].ed));
        check($sformatf("v%0d_partial", i), 32'(out_partial), 32'(vecs[i].ep));
      end
    end
    in_en = 1'b0; flush = 1'b0;

    // Backpressure: five blocks into a four-entry queue
    out_ready = 1'b0;
    for (int b = 0; b < 5; b++) feed_block(16'(b + 1));
    check("bp_drop",  32'(drop_count), 32'd1);
    check("bp_valid", 32'(out_valid),  32'd1);
    check("bp_head",  32'(out_data),   32'd4);
    step();
    check("bp_hold",  32'(out_data),   32'd4);
    out_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      step();
      check($sformatf("bp_pop%0d", b), 32'(out_data), 32'(4 * (b + 1)));
    end
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Full queue: close and pop in the same cycle
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) feed_block(16'(b + 1));
    for (int k = 0; k < 3; k++) begin
      in_data = 16'd5; in_en = 1'b1;
      step();
    end
    out_ready = 1'b1;
    step();
    in_en = 1'b0;
    check("sim_drop", 32'(drop_count), 32'd1);
    check("sim_head", 32'(out_data),   32'd8);
    for (int b = 0; b < 3; b++) begin
      step();
      check($sformatf("sim_pop%0d", b), 32'(out_data), 32'(12 + 4 * b));
    end
    check("sim_valid4", 32'(out_valid), 32'd1);
    step();
    check("sim_empty", 32'(out_valid), 32'd0);

    // Drop counter saturation
    out_ready = 1'b0;
    for (int b = 0; b < 258; b++) feed_block(16'd0);
    check("sat_255", 32'(drop_count), 32'hFF);
    feed_block(16'd0);
    check("sat_hold", 32'(drop_count), 32'hFF);

    // Asynchronous reset mid-cycle with a partial block pending
    in_data = 16'd5; in_en = 1'b1;
    step();
    step();
    in_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid),  32'd0);
    check("arst_data",  32'(out_data),   32'd0);
    check("arst_phase", 32'(phase),      32'd0);
    check("arst_drop",  32'(drop_count), 32'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    feed_block(16'd5);
    check("arst_valid2",  32'(out_valid),   32'd1);
    check("arst_sum",     32'(out_data),    32'd20);
    check("arst_partial", 32'(out_partial), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
